// File: rtl/mem_state.sv
// MEM stage of the five-stage LoongArch pipeline: holds one EXE result,
// waits for the data-SRAM response on loads/stores, extracts load data and
// hands a write-back bundle to WB plus a forwarding/blocking bundle to ID.
module mem_state (
  input  logic        clk,
  input  logic        rst,
  output logic        MEM_allow_in,
  input  logic        EXE_MEM_valid,
  input  logic [31:0] EXE_pc,
  input  logic [37:0] EXE_rf,
  input  logic [6:0]  EXE_mem,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        WB_allow_in,
  output logic        MEM_WB_valid,
  output logic [31:0] MEM_pc,
  output logic [37:0] MEM_rf,
  output logic [38:0] MEM_fwd
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, HELD} state_t;

  state_t      state, state_n;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [37:0] mem_rf;
  logic [6:0]  mem_info;
  logic [31:0] rdata_hold;

  logic        ready_go;
  logic        allow_in;
  logic        latch;
  logic        capture;
  logic [31:0] src;
  logic [31:0] ld_data;
  logic [31:0] wdata;

  logic       mem_req, mem_we, ld_sign;
  logic [1:0] ld_size, addr_off;

  assign {mem_req, mem_we, ld_sign, ld_size, addr_off} = mem_info;

  assign ready_go = mem_valid & ((state == IDLE) | (state == HELD) |
                                 ((state == WAIT_DATA) & data_sram_data_ok));
  assign allow_in = ~mem_valid | (ready_go & WB_allow_in);
  assign latch    = EXE_MEM_valid & allow_in;
  // Response arrives but WB is stalled: park the data so SRAM is free.
  assign capture  = mem_valid & (state == WAIT_DATA) & data_sram_data_ok & ~WB_allow_in;

  // Next state: a departing (or empty) slot takes its state from the incoming
  // instruction; otherwise only a stalled response moves WAIT_DATA to HELD.
  always_comb begin
    state_n = state;
    if (allow_in) begin
      if (EXE_MEM_valid) state_n = EXE_mem[6] ? WAIT_DATA : IDLE;
      else               state_n = IDLE;
    end else if (capture) begin
      state_n = HELD;
    end
  end

  // State, valid bit and held response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state <= state_n;
      if (allow_in) mem_valid <= EXE_MEM_valid;
      if (capture)  rdata_hold <= data_sram_rdata;
    end
  end

  // Pipeline registers loaded from EXE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_pc   <= '0;
      mem_rf   <= '0;
      mem_info <= '0;
    end else if (latch) begin
      mem_pc   <= EXE_pc;
      mem_rf   <= EXE_rf;
      mem_info <= EXE_mem;
    end
  end

  // Live SRAM data only while the request is outstanding; elsewhere the held
  // copy, so stray rdata activity cannot disturb the outputs.
  assign src = (state == WAIT_DATA) ? data_sram_rdata : rdata_hold;

  // Lane selection and sign/zero extension.
  always_comb begin
    ld_data = src;
    case (ld_size)
      2'b00: begin
        logic [7:0] b;
        case (addr_off)
          2'd0:    b = src[7:0];
          2'd1:    b = src[15:8];
          2'd2:    b = src[23:16];
          default: b = src[31:24];
        endcase
        ld_data = {{24{ld_sign & b[7]}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        h = addr_off[1] ? src[31:16] : src[15:0];
        ld_data = {{16{ld_sign & h[15]}}, h};
      end
      default: ld_data = src;
    endcase
  end

  assign wdata = (mem_req & ~mem_we) ? ld_data : mem_rf[31:0];

  assign MEM_allow_in = allow_in;
  assign MEM_WB_valid = mem_valid & ready_go;
  assign MEM_pc       = mem_pc;
  assign MEM_rf       = {mem_rf[37:32], wdata};
  assign MEM_fwd      = {mem_valid & mem_rf[37] & mem_req & ~mem_we & ~ready_go,
                         mem_valid & mem_rf[37], mem_rf[36:32], wdata};

endmodule

// File: tb/tb_mem_state.sv
// Directed bench for mem_state: inputs change 1ns after each rising edge,
// outputs are checked 1ns later, well clear of the next edge.
module tb_mem_state;
  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_allow_in;
  logic        EXE_MEM_valid;
  logic [31:0] EXE_pc;
  logic [37:0] EXE_rf;
  logic [6:0]  EXE_mem;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        WB_allow_in;
  logic        MEM_WB_valid;
  logic [31:0] MEM_pc;
  logic [37:0] MEM_rf;
  logic [38:0] MEM_fwd;

  int checks = 0;
  int failures = 0;

  mem_state dut (
    .clk(clk), .rst(rst), .MEM_allow_in(MEM_allow_in),
    .EXE_MEM_valid(EXE_MEM_valid), .EXE_pc(EXE_pc), .EXE_rf(EXE_rf),
    .EXE_mem(EXE_mem), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .WB_allow_in(WB_allow_in),
    .MEM_WB_valid(MEM_WB_valid), .MEM_pc(MEM_pc), .MEM_rf(MEM_rf),
    .MEM_fwd(MEM_fwd)
  );

  always #5 clk = ~clk;

  // {req, we, sign, size, off}
  localparam logic [6:0] LD_B_2  = 7'b1_0_1_00_10;
  localparam logic [6:0] LD_BU_2 = 7'b1_0_0_00_10;
  localparam logic [6:0] LD_H_2  = 7'b1_0_1_01_10;
  localparam logic [6:0] LD_HU_3 = 7'b1_0_0_01_11;
  localparam logic [6:0] LD_W    = 7'b1_0_1_10_00;
  localparam logic [6:0] ST_W    = 7'b1_1_0_10_00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [37:0] rf, input logic [6:0] m);
    EXE_MEM_valid = 1'b1; EXE_pc = pc; EXE_rf = rf; EXE_mem = m;
    tick();
    EXE_MEM_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; EXE_MEM_valid = 1'b0; EXE_pc = '0; EXE_rf = '0; EXE_mem = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; WB_allow_in = 1'b1;
    tick(); tick();
    rst = 1'b1; settle();
    chk("rst_wb_valid", MEM_WB_valid, 0);
    chk("rst_fwd", MEM_fwd, 0);
    chk("rst_rf", MEM_rf, 0);
    chk("rst_pc", MEM_pc, 0);
    chk("rst_allow", MEM_allow_in, 1);

    // ALU op: one cycle in MEM
    issue(32'h100, {1'b1, 5'd3, 32'h1234}, 7'd0); settle();
    chk("alu_valid", MEM_WB_valid, 1);
    chk("alu_rf", MEM_rf, {1'b1, 5'd3, 32'h1234});
    chk("alu_pc", MEM_pc, 32'h100);
    chk("alu_fwd", MEM_fwd, {1'b0, 1'b1, 5'd3, 32'h1234});
    tick();
    chk("alu_gone", MEM_WB_valid, 0);

    // ld.b signed, off=2, three wait cycles
    issue(32'h104, {1'b1, 5'd5, 32'hDEAD}, LD_B_2);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ldb_wait_valid", MEM_WB_valid, 0);
      chk("ldb_wait_block", MEM_fwd[38], 1);
      chk("ldb_wait_allow", MEM_allow_in, 0);
      tick();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0080_0000; settle();
    chk("ldb_valid", MEM_WB_valid, 1);
    chk("ldb_data", MEM_rf, {1'b1, 5'd5, 32'hFFFF_FF80});
    chk("ldb_unblock", MEM_fwd[38], 0);
    tick(); data_sram_data_ok = 1'b0; settle();
    chk("ldb_gone", MEM_WB_valid, 0);

    // ld.bu same data
    issue(32'h108, {1'b1, 5'd6, 32'h0}, LD_BU_2);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0080_0000; settle();
    chk("ldbu_data", MEM_rf[31:0], 32'h0000_0080);
    tick();
    // ld.h signed off=2
    issue(32'h10C, {1'b1, 5'd7, 32'h0}, LD_H_2);
    data_sram_rdata = 32'h8001_0000; settle();
    chk("ldh_data", MEM_rf[31:0], 32'hFFFF_8001);
    tick();
    // ld.hu off=3: off[0] ignored
    issue(32'h110, {1'b1, 5'd8, 32'h0}, LD_HU_3);
    data_sram_rdata = 32'h8001_0000; settle();
    chk("ldhu_off3", MEM_rf[31:0], 32'h0000_8001);
    tick();
    // ld.w
    issue(32'h114, {1'b1, 5'd9, 32'h0}, LD_W);
    data_sram_rdata = 32'hCAFE_BABE; settle();
    chk("ldw_data", MEM_rf[31:0], 32'hCAFE_BABE);
    tick();
    // store: waits for data_ok, rf passes through
    data_sram_data_ok = 1'b0;
    issue(32'h118, {1'b0, 5'd0, 32'h0000_0040}, ST_W); settle();
    chk("st_wait", MEM_WB_valid, 0);
    chk("st_noblock", MEM_fwd[38], 0);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5A5A_5A5A; settle();
    chk("st_done", MEM_WB_valid, 1);
    chk("st_rf", MEM_rf, {1'b0, 5'd0, 32'h0000_0040});
    tick(); data_sram_data_ok = 1'b0;

    // response while WB stalled -> HELD
    issue(32'h11C, {1'b1, 5'd10, 32'h0}, LD_W);
    WB_allow_in = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222; settle();
    chk("hold_ready", MEM_WB_valid, 1);
    chk("hold_allow0", MEM_allow_in, 0);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h9999_9999; settle();
    chk("held_valid", MEM_WB_valid, 1);
    chk("held_data", MEM_rf[31:0], 32'h1111_2222);
    chk("held_allow", MEM_allow_in, 0);
    tick(); settle();
    chk("held_data2", MEM_rf[31:0], 32'h1111_2222);
    WB_allow_in = 1'b1; settle();
    chk("held_release", MEM_WB_valid, 1);
    chk("held_allow1", MEM_allow_in, 1);
    tick(); settle();
    chk("held_once", MEM_WB_valid, 0);

    // back-to-back loads, 1-cycle response each
    issue(32'h200, {1'b1, 5'd11, 32'h0}, LD_W);
    EXE_MEM_valid = 1'b1; EXE_pc = 32'h204; EXE_rf = {1'b1, 5'd12, 32'h0}; EXE_mem = LD_W;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_000A; settle();
    chk("b2b_a_valid", MEM_WB_valid, 1);
    chk("b2b_a_pc", MEM_pc, 32'h200);
    chk("b2b_a_data", MEM_rf[31:0], 32'h0000_000A);
    chk("b2b_allow", MEM_allow_in, 1);
    tick();
    EXE_MEM_valid = 1'b0; data_sram_rdata = 32'h0000_000B; settle();
    chk("b2b_b_valid", MEM_WB_valid, 1);
    chk("b2b_b_pc", MEM_pc, 32'h204);
    chk("b2b_b_data", MEM_rf, {1'b1, 5'd12, 32'h0000_000B});
    tick(); data_sram_data_ok = 1'b0; settle();
    chk("b2b_end", MEM_WB_valid, 0);

    // spurious data_ok while empty
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555; settle();
    chk("spur_valid", MEM_WB_valid, 0);
    chk("spur_rf", MEM_rf[31:0], 32'h1111_2222);
    chk("spur_fwd_we", MEM_fwd[37], 0);
    tick(); data_sram_data_ok = 1'b0; settle();
    chk("spur_after", MEM_rf[31:0], 32'h1111_2222);
    chk("spur_allow", MEM_allow_in, 1);

    // reset during WAIT_DATA
    issue(32'h300, {1'b1, 5'd13, 32'h0}, LD_W);
    rst = 1'b0; tick(); rst = 1'b1; settle();
    chk("rstw_valid", MEM_WB_valid, 0);
    chk("rstw_fwd", MEM_fwd, 0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777; settle();
    chk("late_ok_valid", MEM_WB_valid, 0);
    chk("late_ok_rf", MEM_rf, 0);
    tick(); data_sram_data_ok = 1'b0; settle();
    chk("late_ok_after", MEM_WB_valid, 0);
    chk("late_ok_allow", MEM_allow_in, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
